threat_response_ctrl: RTL and testbench

Parametrised successor to the threat/auth decision FSM in the EW pipeline. It sits after threat classification and authentication, and before the RF channel selector. It adds the following to the basic MONITOR/VALIDATE/JAMMED/BLACKOUT/RECOVERY flow:
- N-channel hopping with a per-channel jammed-channel blacklist.
- An auth handshake with timeout.
- Programmable blackout and recovery dwell timers.
- A hop counter.

---
 rtl/ew_pkg.sv | 15 +
 rtl/threat_response_ctrl_if.sv | 38 +++
 rtl/chan_select.sv | 33 +++
 rtl/threat_response_ctrl.sv | 146 ++++++++++++++
 tb/tb_threat_response_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ew_pkg.sv
// Shared types for the EW threat-response pipeline: FSM state encoding and
// the default set of threat classes that indicate jamming.
package ew_pkg;

  typedef enum logic [2:0] {
    ST_MONITOR  = 3'd0,
    ST_VALIDATE = 3'd1,
    ST_JAMMED   = 3'd2,
    ST_BLACKOUT = 3'd3,
    ST_RECOVERY = 3'd4
  } state_e;

  localparam logic [7:0] DEFAULT_JAM_MASK = 8'h11;

endpackage

// File: rtl/threat_response_ctrl_if.sv
// Bundle between the threat/auth front end (master) and the response
// controller (slave). Outputs of the controller feed the RF channel selector.
interface threat_response_ctrl_if
  import ew_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int THREAT_W = 8,
  parameter int ID_W     = 4
) ();

  localparam int CH_W = $clog2(NUM_CH);

  logic [THREAT_W-1:0] threat_vector;
  logic                known_threat;
  logic [ID_W-1:0]     threat_id;
  logic                auth_valid;
  logic                auth_done;
  logic [CH_W-1:0]     safest_channel;

  state_e              state;
  logic [CH_W-1:0]     current_channel;
  logic                hop_req;
  logic [7:0]          hop_count;
  logic [NUM_CH-1:0]   jam_map;
  logic [ID_W-1:0]     latched_id;
  logic                blackout_active;

  modport master (
    output threat_vector, known_threat, threat_id, auth_valid, auth_done, safest_channel,
    input  state, current_channel, hop_req, hop_count, jam_map, latched_id, blackout_active
  );

  modport slave (
    input  threat_vector, known_threat, threat_id, auth_valid, auth_done, safest_channel,
    output state, current_channel, hop_req, hop_count, jam_map, latched_id, blackout_active
  );

endinterface

// File: rtl/chan_select.sv
// Picks the channel to hop to: the scanner's safest channel when usable,
// otherwise the lowest-index channel that is not blacklisted.
module chan_select #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] jam_map_i,
  input  logic [CH_W-1:0]   current_channel_i,
  input  logic [CH_W-1:0]   safest_channel_i,
  output logic [CH_W-1:0]   next_ch_o,
  output logic              none_free_o
);

  logic            safe_ok;
  logic [CH_W-1:0] lowest_free;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    lowest_free = '0;
    safe_ok     = 1'b0;
    // Scan downward so the last hit wins, leaving the lowest free index.
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (!jam_map_i[c]) lowest_free = CH_W'(c);
    end
    if (int'(safest_channel_i) < NUM_CH) begin
      safe_ok = !jam_map_i[safest_channel_i] && (safest_channel_i != current_channel_i);
    end
  end

  assign next_ch_o   = safe_ok ? safest_channel_i : lowest_free;
  assign none_free_o = &jam_map_i;

endmodule

// File: rtl/threat_response_ctrl.sv
// Threat/auth decision FSM with channel hopping, jammed-channel blacklist,
// auth timeout and programmable blackout/recovery dwell.
module threat_response_ctrl
  import ew_pkg::*;
#(
  parameter int                  NUM_CH          = 4,
  parameter int                  THREAT_W        = 8,
  parameter int                  ID_W            = 4,
  parameter logic [THREAT_W-1:0] JAM_MASK        = THREAT_W'(DEFAULT_JAM_MASK),
  parameter int                  AUTH_TIMEOUT    = 4,
  parameter int                  BLACKOUT_CYCLES = 16,
  parameter int                  RECOVERY_CYCLES = 8
) (
  input logic                   clk,
  input logic                   reset,
  threat_response_ctrl_if.slave ctrl_if
);

  localparam int CH_W      = $clog2(NUM_CH);
  localparam int MAX_AB    = (AUTH_TIMEOUT > BLACKOUT_CYCLES) ? AUTH_TIMEOUT : BLACKOUT_CYCLES;
  localparam int MAX_DWELL = (MAX_AB > RECOVERY_CYCLES) ? MAX_AB : RECOVERY_CYCLES;
  localparam int TMR_W     = $clog2(MAX_DWELL + 1);

  localparam logic [TMR_W-1:0] AUTH_LAST     = TMR_W'(AUTH_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] BLACKOUT_LAST = TMR_W'(BLACKOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] RECOVERY_LAST = TMR_W'(RECOVERY_CYCLES - 1);

  state_e            state_q;
  logic [CH_W-1:0]   current_channel_q;
  logic              hop_req_q;
  logic [7:0]        hop_count_q;
  logic [NUM_CH-1:0] jam_map_q;
  logic [ID_W-1:0]   latched_id_q;
  logic              blackout_active_q;
  logic [TMR_W-1:0]  timer_q;

  logic [NUM_CH-1:0] jam_upd;
  logic [CH_W-1:0]   next_ch;
  logic              none_free;
  logic              threat_seen;
  logic              jam_hit;

  // Blacklist as it will be after this cycle, so the selector never picks the channel being jammed.
  assign jam_upd     = jam_map_q | (NUM_CH'(1) << current_channel_q);
  assign threat_seen = |ctrl_if.threat_vector;
  assign jam_hit     = |(ctrl_if.threat_vector & JAM_MASK);

  chan_select #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_chan_select (
    .jam_map_i         (jam_upd),
    .current_channel_i (current_channel_q),
    .safest_channel_i  (ctrl_if.safest_channel),
    .next_ch_o         (next_ch),
    .none_free_o       (none_free)
  );

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values.
    if (reset) begin
      state_q           <= ST_MONITOR;
      current_channel_q <= '0;
      hop_req_q         <= 1'b0;
      hop_count_q       <= '0;
      jam_map_q         <= '0;
      latched_id_q      <= '0;
      blackout_active_q <= 1'b0;
      timer_q           <= '0;
    end else begin
      hop_req_q <= 1'b0;
      case (state_q)
        ST_MONITOR: begin
          if (threat_seen) begin
            latched_id_q <= ctrl_if.threat_id;
            timer_q      <= '0;
            state_q      <= ctrl_if.known_threat ? ST_RECOVERY : ST_VALIDATE;
          end
        end
        ST_VALIDATE: begin
          timer_q <= timer_q + 1'b1;
          // A result arriving on the timeout cycle still counts.
          if (ctrl_if.auth_done) begin
            timer_q <= '0;
            if (!ctrl_if.auth_valid) begin
              state_q           <= ST_BLACKOUT;
              blackout_active_q <= 1'b1;
            end else if (jam_hit) begin
              state_q <= ST_JAMMED;
            end else begin
              state_q <= ST_MONITOR;
            end
          end else if (timer_q == AUTH_LAST) begin
            timer_q           <= '0;
            state_q           <= ST_BLACKOUT;
            blackout_active_q <= 1'b1;
          end
        end
        ST_JAMMED: begin
          jam_map_q <= jam_upd;
          if (none_free) begin
            state_q           <= ST_BLACKOUT;
            blackout_active_q <= 1'b1;
          end else begin
            current_channel_q <= next_ch;
            hop_req_q         <= 1'b1;
            if (hop_count_q != 8'hFF) hop_count_q <= hop_count_q + 8'd1;
            state_q <= ST_MONITOR;
          end
        end
        ST_BLACKOUT: begin
          if (timer_q == BLACKOUT_LAST) begin
            timer_q           <= '0;
            blackout_active_q <= 1'b0;
            state_q           <= ST_RECOVERY;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_RECOVERY: begin
          if (timer_q == RECOVERY_LAST) begin
            timer_q   <= '0;
            jam_map_q <= '0;
            state_q   <= ST_MONITOR;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          state_q           <= ST_MONITOR;
          timer_q           <= '0;
          blackout_active_q <= 1'b0;
        end
      endcase
    end
  end

  assign ctrl_if.state           = state_q;
  assign ctrl_if.current_channel = current_channel_q;
  assign ctrl_if.hop_req         = hop_req_q;
  assign ctrl_if.hop_count       = hop_count_q;
  assign ctrl_if.jam_map         = jam_map_q;
  assign ctrl_if.latched_id      = latched_id_q;
  assign ctrl_if.blackout_active = blackout_active_q;

endmodule

// File: tb/tb_threat_response_ctrl.sv
// Scoreboard bench for threat_response_ctrl: stimulus queues the expected
// state-change/hop events, a monitor pops and compares each one it observes.
module tb_threat_response_ctrl;
  import ew_pkg::*;

  localparam int NUM_CH   = 4;
  localparam int THREAT_W = 8;
  localparam int ID_W     = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  threat_response_ctrl_if #(.NUM_CH(NUM_CH), .THREAT_W(THREAT_W), .ID_W(ID_W)) bus ();

  threat_response_ctrl #(
    .NUM_CH          (NUM_CH),
    .THREAT_W        (THREAT_W),
    .ID_W            (ID_W),
    .JAM_MASK        (8'h11),
    .AUTH_TIMEOUT    (4),
    .BLACKOUT_CYCLES (16),
    .RECOVERY_CYCLES (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ctrl_if (bus)
  );

  // One expected event: outputs seen when the state changes or hop_req is high.
  // cyc = sampling cycles since the previous event (0 = not checked).
  typedef struct {
    int st;
    int ch;
    int hop;
    int hc;
    int jam;
    int id;
    int bo;
    int cyc;
  } evt_t;

  evt_t   exp_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  int     n_evt   = 0;
  bit     mon_en  = 1'b0;
  state_e prev_st = ST_MONITOR;
  int     since   = 0;
  evt_t   cur_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void push(input int st, input int ch, input int hop, input int hc,
                               input int jam, input int id, input int bo, input int cyc);
    evt_t e;
    e.st = st; e.ch = ch; e.hop = hop; e.hc = hc;
    e.jam = jam; e.id = id; e.bo = bo; e.cyc = cyc;
    exp_q.push_back(e);
  endfunction

  task automatic snap(input string tag, input int st, input int ch, input int hop, input int hc,
                      input int jam, input int id, input int bo);
    check({tag, ".state"},           32'(bus.state),           st);
    check({tag, ".current_channel"}, 32'(bus.current_channel), ch);
    check({tag, ".hop_req"},         32'(bus.hop_req),         hop);
    check({tag, ".hop_count"},       32'(bus.hop_count),       hc);
    check({tag, ".jam_map"},         32'(bus.jam_map),         jam);
    check({tag, ".latched_id"},      32'(bus.latched_id),      id);
    check({tag, ".blackout_active"}, 32'(bus.blackout_active), bo);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int n = 0; n < budget && exp_q.size() != 0; n++) @(negedge clk);
    check({tag, ".pending_events"}, 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  task automatic idle_inputs();
    bus.threat_vector = '0;
    bus.known_threat  = 1'b0;
    bus.threat_id     = '0;
    bus.auth_valid    = 1'b0;
    bus.auth_done     = 1'b0;
  endtask

  // Monitor: outputs are stable at the falling edge.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (mon_en) begin
        since++;
        if (bus.state != prev_st || bus.hop_req) begin
          n_evt++;
          check($sformatf("evt%0d.expected_pending", n_evt), 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            cur_e = exp_q.pop_front();
            check($sformatf("evt%0d.state", n_evt),           32'(bus.state),           cur_e.st);
            check($sformatf("evt%0d.current_channel", n_evt), 32'(bus.current_channel), cur_e.ch);
            check($sformatf("evt%0d.hop_req", n_evt),         32'(bus.hop_req),         cur_e.hop);
            check($sformatf("evt%0d.hop_count", n_evt),       32'(bus.hop_count),       cur_e.hc);
            check($sformatf("evt%0d.jam_map", n_evt),         32'(bus.jam_map),         cur_e.jam);
            check($sformatf("evt%0d.latched_id", n_evt),      32'(bus.latched_id),      cur_e.id);
            check($sformatf("evt%0d.blackout_active", n_evt), 32'(bus.blackout_active), cur_e.bo);
            if (cur_e.cyc != 0)
              check($sformatf("evt%0d.dwell_cycles", n_evt), 32'(since), cur_e.cyc);
          end
          since = 0;
        end
        prev_st = bus.state;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    reset = 1'b1;
    idle_inputs();
    bus.safest_channel = '0;

    // 1: reset and quiet input.
    repeat (2) @(negedge clk);
    reset = 1'b0;
    snap("reset", ST_MONITOR, 0, 0, 0, 0, 0, 0);
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("idle%0d.state", i),   32'(bus.state),           ST_MONITOR);
      check($sformatf("idle%0d.channel", i), 32'(bus.current_channel), 0);
      check($sformatf("idle%0d.hops", i),    32'(bus.hop_count),       0);
    end

    // 2: jam threat, auth ok, safest channel 2 usable.
    @(negedge clk);
    bus.threat_vector  = 8'h01;
    bus.threat_id      = 4'h5;
    bus.safest_channel = 2'd2;
    push(ST_VALIDATE, 0, 0, 0, 4'b0000, 5, 0, 0);
    @(negedge clk);
    bus.auth_done  = 1'b1;
    bus.auth_valid = 1'b1;
    push(ST_JAMMED, 0, 0, 0, 4'b0000, 5, 0, 1);
    @(negedge clk);
    idle_inputs();
    push(ST_MONITOR, 2, 1, 1, 4'b0001, 5, 0, 1);
    drain("hop_safe", 10);
    repeat (3) @(negedge clk);

    // 3: auth timeout, full blackout and recovery dwell.
    @(negedge clk);
    bus.threat_vector = 8'h02;
    bus.threat_id     = 4'hA;
    push(ST_VALIDATE, 2, 0, 1, 4'b0001, 10, 0, 0);
    @(negedge clk);
    idle_inputs();
    push(ST_BLACKOUT, 2, 0, 1, 4'b0001, 10, 1, 4);
    push(ST_RECOVERY, 2, 0, 1, 4'b0001, 10, 0, 16);
    push(ST_MONITOR,  2, 0, 1, 4'b0000, 10, 0, 8);
    drain("timeout", 40);
    repeat (2) @(negedge clk);

    // 4: repeated jams with safest channel stuck on 0.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    snap("reset2", ST_MONITOR, 0, 0, 0, 0, 0, 0);
    bus.safest_channel = 2'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.threat_vector = 8'h10;
      bus.threat_id     = 4'h3;
      push(ST_VALIDATE, k, 0, k, (1 << k) - 1, 3, 0, 0);
      @(negedge clk);
      bus.auth_done  = 1'b1;
      bus.auth_valid = 1'b1;
      push(ST_JAMMED, k, 0, k, (1 << k) - 1, 3, 0, 1);
      @(negedge clk);
      idle_inputs();
      if (k < 3) begin
        push(ST_MONITOR, k + 1, 1, k + 1, (1 << (k + 1)) - 1, 3, 0, 1);
      end else begin
        push(ST_BLACKOUT, 3, 0, 3, 4'b1111, 3, 1, 1);
        push(ST_RECOVERY, 3, 0, 3, 4'b1111, 3, 0, 16);
        push(ST_MONITOR,  3, 0, 3, 4'b0000, 3, 0, 8);
      end
      drain($sformatf("jam%0d", k), 40);
      repeat (2) @(negedge clk);
    end

    // 5: known threat goes straight to recovery; threats ignored there.
    @(negedge clk);
    bus.threat_vector = 8'h10;
    bus.known_threat  = 1'b1;
    bus.threat_id     = 4'h9;
    push(ST_RECOVERY, 3, 0, 3, 4'b0000, 9, 0, 0);
    push(ST_MONITOR,  3, 0, 3, 4'b0000, 9, 0, 8);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      bus.threat_vector = 8'h11;
      bus.known_threat  = 1'b0;
      bus.threat_id     = 4'hE;
      bus.auth_done     = 1'b1;
      bus.auth_valid    = 1'b1;
      @(negedge clk);
    end
    idle_inputs();
    drain("known", 20);
    repeat (2) @(negedge clk);

    // 6a: auth_done lands on the timeout cycle; auth result wins.
    @(negedge clk);
    bus.threat_vector = 8'h01;
    bus.threat_id     = 4'h7;
    push(ST_VALIDATE, 3, 0, 3, 4'b0000, 7, 0, 0);
    push(ST_JAMMED,   3, 0, 3, 4'b0000, 7, 0, 4);
    push(ST_MONITOR,  0, 1, 4, 4'b1000, 7, 0, 1);
    repeat (4) @(negedge clk);
    bus.auth_done  = 1'b1;
    bus.auth_valid = 1'b1;
    @(negedge clk);
    idle_inputs();
    drain("auth_vs_timeout", 10);
    repeat (2) @(negedge clk);

    // 6b: auth rejected, reset during the 5th blackout cycle.
    @(negedge clk);
    bus.threat_vector = 8'h04;
    bus.threat_id     = 4'h2;
    push(ST_VALIDATE, 0, 0, 4, 4'b1000, 2, 0, 0);
    @(negedge clk);
    bus.auth_done  = 1'b1;
    bus.auth_valid = 1'b0;
    push(ST_BLACKOUT, 0, 0, 4, 4'b1000, 2, 1, 1);
    @(negedge clk);
    idle_inputs();
    push(ST_MONITOR, 0, 0, 0, 4'b0000, 0, 0, 5);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    snap("mid_blackout_reset", ST_MONITOR, 0, 0, 0, 0, 0, 0);
    drain("mid_blackout_reset", 10);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
